// File: rtl/dvga_timing_gen_pkg.sv
// Shared timing defaults, run-state type and window helper for the dvga timing generator.
// Default raster is 640x480 @ 60 Hz on a 25 MHz pixel clock, sync pulses active-low.
package dvga_timing_gen_pkg;

    localparam int DEF_HACT  = 640;
    localparam int DEF_HFP   = 16;
    localparam int DEF_HSYNC = 96;
    localparam int DEF_HBP   = 48;
    localparam int DEF_VACT  = 480;
    localparam int DEF_VFP   = 10;
    localparam int DEF_VSYNC = 2;
    localparam int DEF_VBP   = 33;
    localparam logic DEF_HPOL = 1'b0;
    localparam logic DEF_VPOL = 1'b0;

    localparam int CNT_W = 10;

    typedef enum logic {
        ST_PARKED = 1'b0,
        ST_RUN    = 1'b1
    } run_state_t;

    // Half-open window test [lo, hi) on a counter value.
    function automatic logic in_win(input logic [CNT_W-1:0] x,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
        return (x >= lo) && (x < hi);
    endfunction

endpackage

// File: rtl/dvga_wrap_cnt.sv
// Wrapping counter with hold, load-to-terminal and carry-out; exposes its next value so
// the parent can register outputs that line up with the count.
module dvga_wrap_cnt #(
    parameter int             W    = 10,
    parameter logic [W-1:0]   TERM = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         load,
    output logic [W-1:0] q,
    output logic [W-1:0] d,
    output logic         carry
);

    always_comb begin
        d = q;
        if (load) begin
            d = TERM;
        end else if (inc) begin
            d = (q == TERM) ? '0 : q + W'(1);
        end
    end

    assign carry = inc && !load && (q == TERM);

    // Reset parks the count at its terminal value so the first increment wraps to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= TERM;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/dvga_timing_gen.sv
// Display timing generator: raster counters, sync/blank, one-cycle-lookahead FIFO read request
// and sticky underflow flag. Every output is a register aligned with hcount/vcount.
module dvga_timing_gen
    import dvga_timing_gen_pkg::*;
#(
    parameter int   HACT  = DEF_HACT,
    parameter int   HFP   = DEF_HFP,
    parameter int   HSYNC = DEF_HSYNC,
    parameter int   HBP   = DEF_HBP,
    parameter int   VACT  = DEF_VACT,
    parameter int   VFP   = DEF_VFP,
    parameter int   VSYNC = DEF_VSYNC,
    parameter int   VBP   = DEF_VBP,
    parameter logic HPOL  = DEF_HPOL,
    parameter logic VPOL  = DEF_VPOL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic             clr_underflow,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hs,
    output logic             vs,
    output logic             blank_n,
    output logic             pix_req,
    output logic             line_start,
    output logic             frame_start,
    output logic             underflow
);

    // Totals must fit the 10-bit counters (HTOT, VTOT <= 1024).
    localparam int HTOT = HACT + HFP + HSYNC + HBP;
    localparam int VTOT = VACT + VFP + VSYNC + VBP;

    localparam logic [CNT_W-1:0] HLAST  = CNT_W'(HTOT - 1);
    localparam logic [CNT_W-1:0] VLAST  = CNT_W'(VTOT - 1);
    localparam logic [CNT_W-1:0] HACT_W = CNT_W'(HACT);
    localparam logic [CNT_W-1:0] VACT_W = CNT_W'(VACT);
    localparam logic [CNT_W-1:0] HS_LO  = CNT_W'(HACT + HFP);
    localparam logic [CNT_W-1:0] HS_HI  = CNT_W'(HACT + HFP + HSYNC);
    localparam logic [CNT_W-1:0] VS_LO  = CNT_W'(VACT + VFP);
    localparam logic [CNT_W-1:0] VS_HI  = CNT_W'(VACT + VFP + VSYNC);

    run_state_t       state;
    logic             h_inc;
    logic             h_carry;
    logic             v_carry;
    logic [CNT_W-1:0] h_d;
    logic [CNT_W-1:0] v_d;
    logic [CNT_W-1:0] h_n;
    logic [CNT_W-1:0] v_n;
    logic             act_d;
    logic             act_n;

    // The first enabled cycle only announces the request; counting starts one cycle later.
    assign h_inc = en && (state == ST_RUN);

    dvga_wrap_cnt #(.W(CNT_W), .TERM(HLAST)) u_hcnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (h_inc),
        .load  (!en),
        .q     (hcount),
        .d     (h_d),
        .carry (h_carry)
    );

    dvga_wrap_cnt #(.W(CNT_W), .TERM(VLAST)) u_vcnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (h_carry),
        .load  (!en),
        .q     (vcount),
        .d     (v_d),
        .carry (v_carry)
    );

    // Position after the one about to be presented, for the lookahead request.
    always_comb begin
        h_n = h_d + CNT_W'(1);
        v_n = v_d;
        if (h_d == HLAST) begin
            h_n = '0;
            v_n = (v_d == VLAST) ? '0 : v_d + CNT_W'(1);
        end
    end

    assign act_d = (h_d < HACT_W) && (v_d < VACT_W);
    assign act_n = (h_n < HACT_W) && (v_n < VACT_W);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_PARKED;
            hs          <= ~HPOL;
            vs          <= ~VPOL;
            blank_n     <= 1'b0;
            pix_req     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            state       <= en ? ST_RUN : ST_PARKED;
            hs          <= (en && in_win(h_d, HS_LO, HS_HI)) ? HPOL : ~HPOL;
            vs          <= (en && in_win(v_d, VS_LO, VS_HI)) ? VPOL : ~VPOL;
            blank_n     <= en && act_d;
            pix_req     <= en && act_n;
            line_start  <= h_carry;
            frame_start <= h_carry && v_carry;
            // A new underflow event outranks a clear in the same cycle.
            if (pix_req && fifo_empty) begin
                underflow <= 1'b1;
            end else if (clr_underflow) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule
